// File: rtl/mini_core_p.sv
// Three-stage (IF/LD/EX) accumulator-free memory-to-memory core with
// multi-cycle multiply, EX->LD operand forwarding and a preloadable imem/dmem.
module mini_core_p #(
  parameter int DW      = 8,
  parameter int AW      = 6,
  parameter int IAW     = 5,
  parameter int MUL_CYC = 4,
  parameter int CW      = 16,
  localparam int IW     = 2 + 3*AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           imem_we,
  input  logic [IAW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_wdata,
  input  logic           dmem_we,
  input  logic [AW-1:0]  dmem_addr,
  input  logic [DW-1:0]  dmem_wdata,
  output logic [DW-1:0]  dmem_rdata,
  output logic           busy,
  output logic           halted,
  output logic [CW-1:0]  retired
);
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_HALT = 2'b11} op_e;

  localparam int MCW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  logic [IW-1:0] imem [2**IAW];
  logic [DW-1:0] dmem [2**AW];

  logic           busy_q, busy_d, halted_q, halted_d;
  logic [CW-1:0]  retired_q, retired_d;
  logic [IAW-1:0] pc_q, pc_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic           if_vld_q, if_vld_d, ld_vld_q, ld_vld_d, ex_vld_q, ex_vld_d;
  logic [IW-1:0]  if_ir_q, if_ir_d, ld_ir_q, ld_ir_d;
  op_e            ex_op_q, ex_op_d;
  logic [AW-1:0]  ex_dst_q, ex_dst_d;
  logic [DW-1:0]  ex_a_q, ex_a_d, ex_b_q, ex_b_d;

  logic           freeze, ex_halt, ex_we;
  logic [DW-1:0]  ex_res, op_a, op_b;
  logic [AW-1:0]  ld_s1, ld_s2, ld_d;
  op_e            ld_op;

  assign ld_op = op_e'(ld_ir_q[IW-1 -: 2]);
  assign ld_s1 = ld_ir_q[3*AW-1 -: AW];
  assign ld_s2 = ld_ir_q[2*AW-1 -: AW];
  assign ld_d  = ld_ir_q[AW-1:0];

  // A mul sits in EX until its last cycle; everything upstream holds meanwhile.
  assign freeze  = ex_vld_q && (ex_op_q == OP_MUL) && (mcnt_q != MCW'(MUL_CYC-1));
  assign ex_halt = ex_vld_q && (ex_op_q == OP_HALT);
  assign ex_we   = busy_q && ex_vld_q && (ex_op_q != OP_HALT) && !freeze;

  always_comb begin
    ex_res = ex_a_q + ex_b_q;
    case (ex_op_q)
      OP_SUB:  ex_res = ex_a_q - ex_b_q;
      OP_MUL:  ex_res = ex_a_q * ex_b_q;
      default: ex_res = ex_a_q + ex_b_q;
    endcase
  end

  // The EX write lands on the same edge LD samples dmem, so bypass it.
  assign op_a = (ex_we && ex_dst_q == ld_s1) ? ex_res : dmem[ld_s1];
  assign op_b = (ex_we && ex_dst_q == ld_s2) ? ex_res : dmem[ld_s2];

  always_comb begin
    busy_d    = busy_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    pc_d      = pc_q;
    mcnt_d    = mcnt_q;
    if_vld_d  = if_vld_q;
    if_ir_d   = if_ir_q;
    ld_vld_d  = ld_vld_q;
    ld_ir_d   = ld_ir_q;
    ex_vld_d  = ex_vld_q;
    ex_op_d   = ex_op_q;
    ex_dst_d  = ex_dst_q;
    ex_a_d    = ex_a_q;
    ex_b_d    = ex_b_q;
    if (start && !busy_q) begin
      busy_d    = 1'b1;
      halted_d  = 1'b0;
      retired_d = '0;
      pc_d      = '0;
      mcnt_d    = '0;
      if_vld_d  = 1'b0;
      ld_vld_d  = 1'b0;
      ex_vld_d  = 1'b0;
    end else if (busy_q) begin
      if (ex_we) retired_d = retired_q + CW'(1);
      if (ex_halt) begin
        busy_d   = 1'b0;
        halted_d = 1'b1;
        if_vld_d = 1'b0;
        ld_vld_d = 1'b0;
        ex_vld_d = 1'b0;
      end else if (freeze) begin
        mcnt_d = mcnt_q + MCW'(1);
      end else begin
        mcnt_d   = '0;
        pc_d     = pc_q + IAW'(1);
        if_vld_d = 1'b1;
        if_ir_d  = imem[pc_q];
        ld_vld_d = if_vld_q;
        ld_ir_d  = if_ir_q;
        ex_vld_d = ld_vld_q;
        ex_op_d  = ld_op;
        ex_dst_d = ld_d;
        ex_a_d   = op_a;
        ex_b_d   = op_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
      pc_q      <= '0;
      mcnt_q    <= '0;
      if_vld_q  <= 1'b0;
      if_ir_q   <= '0;
      ld_vld_q  <= 1'b0;
      ld_ir_q   <= '0;
      ex_vld_q  <= 1'b0;
      ex_op_q   <= OP_ADD;
      ex_dst_q  <= '0;
      ex_a_q    <= '0;
      ex_b_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      pc_q      <= pc_d;
      mcnt_q    <= mcnt_d;
      if_vld_q  <= if_vld_d;
      if_ir_q   <= if_ir_d;
      ld_vld_q  <= ld_vld_d;
      ld_ir_q   <= ld_ir_d;
      ex_vld_q  <= ex_vld_d;
      ex_op_q   <= ex_op_d;
      ex_dst_q  <= ex_dst_d;
      ex_a_q    <= ex_a_d;
      ex_b_q    <= ex_b_d;
    end
  end

  // Memories are not reset; preload ports are only live while idle.
  always_ff @(posedge clk) begin
    if (!busy_q && imem_we) imem[imem_addr] <= imem_wdata;
    if (ex_we) dmem[ex_dst_q] <= ex_res;
    else if (!busy_q && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  assign dmem_rdata = dmem[dmem_addr];
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign retired    = retired_q;
endmodule

// File: tb/tb_mini_core_p.sv
// Scoreboard bench for mini_core_p: programs are preloaded, expected dmem
// results are queued as the program is written and drained once the core idles.
module tb_mini_core_p;
  localparam int DW = 8, AW = 6, IAW = 5, CW = 16, IW = 2 + 3*AW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           imem_we = 1'b0;
  logic [IAW-1:0] imem_addr = '0;
  logic [IW-1:0]  imem_wdata = '0;
  logic           dmem_we = 1'b0;
  logic [AW-1:0]  dmem_addr = '0;
  logic [DW-1:0]  dmem_wdata = '0;
  logic [DW-1:0]  dmem_rdata;
  logic           busy, halted;
  logic [CW-1:0]  retired;

  mini_core_p #(.DW(DW), .AW(AW), .IAW(IAW), .MUL_CYC(4), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  string         exp_tag_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_val_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input logic [1:0] op, input int s1, input int s2, input int d);
    logic [AW-1:0] a, b, c;
    a = s1[AW-1:0]; b = s2[AW-1:0]; c = d[AW-1:0];
    return {op, a, b, c};
  endfunction

  task automatic wr_i(input int a, input logic [IW-1:0] w);
    @(negedge clk);
    imem_we = 1'b1; imem_addr = a[IAW-1:0]; imem_wdata = w;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic wr_d(input int a, input int v);
    @(negedge clk);
    dmem_we = 1'b1; dmem_addr = a[AW-1:0]; dmem_wdata = v[DW-1:0];
    @(negedge clk);
    dmem_we = 1'b0;
  endtask

  task automatic rd_d(input int a, output logic [DW-1:0] v);
    dmem_addr = a[AW-1:0];
    #1 v = dmem_rdata;
  endtask

  task automatic expect_d(input string tag, input int a, input int v);
    exp_tag_q.push_back(tag);
    exp_addr_q.push_back(a[AW-1:0]);
    exp_val_q.push_back(v[DW-1:0]);
  endtask

  task automatic drain();
    logic [DW-1:0] v;
    while (exp_tag_q.size() > 0) begin
      string t; logic [AW-1:0] a; logic [DW-1:0] e;
      t = exp_tag_q.pop_front(); a = exp_addr_q.pop_front(); e = exp_val_q.pop_front();
      rd_d(int'(a), v);
      chk(t, 32'(v), 32'(e));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int c, ca, cm;
    logic [DW-1:0] v;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retired", 32'(retired), 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", 32'(busy), 0);

    // single add, write timing
    wr_d(0, 5); wr_d(1, 7); wr_d(2, 0);
    wr_i(0, ins(2'b00, 0, 1, 2)); wr_i(1, ins(2'b11, 0, 0, 0));
    pulse_start();
    repeat (3) @(negedge clk);
    rd_d(2, v); chk("t1_before_edge3", 32'(v), 0);
    @(negedge clk);
    rd_d(2, v); chk("t1_at_edge3", 32'(v), 12);
    wait_idle(c);
    chk("t1_cycles", 32'(c + 4), 5);
    chk("t1_halted", 32'(halted), 1);
    chk("t1_retired", 32'(retired), 1);

    // back-to-back RAW, both-operand forward
    wr_d(3, 0); wr_d(4, 0);
    wr_i(0, ins(2'b00, 0, 1, 2)); expect_d("t2_d2", 2, 12);
    wr_i(1, ins(2'b01, 2, 0, 3)); expect_d("t2_d3", 3, 7);
    wr_i(2, ins(2'b00, 3, 3, 4)); expect_d("t2_d4", 4, 14);
    wr_i(3, ins(2'b11, 0, 0, 0));
    pulse_start(); wait_idle(c);
    chk("t2_cycles", 32'(c), 7);
    chk("t2_retired", 32'(retired), 3);
    drain();

    // all-add reference vs mul
    wr_d(0, 20); wr_d(1, 13); wr_d(2, 0); wr_d(5, 0);
    wr_i(0, ins(2'b00, 0, 1, 2)); expect_d("t3a_d2", 2, 33);
    wr_i(1, ins(2'b00, 2, 0, 5)); expect_d("t3a_d5", 5, 53);
    wr_i(2, ins(2'b11, 0, 0, 0));
    pulse_start(); wait_idle(ca);
    chk("t3a_cycles", 32'(ca), 6);
    drain();
    wr_d(0, 20); wr_d(2, 0); wr_d(5, 0);
    wr_i(0, ins(2'b10, 0, 1, 2)); expect_d("t3m_d2", 2, 4);
    expect_d("t3m_d5", 5, 24);
    pulse_start(); wait_idle(cm);
    chk("t3m_cycles", 32'(cm), 9);
    chk("t3m_extra", 32'(cm - ca), 3);
    chk("t3m_retired", 32'(retired), 2);
    drain();

    // modular wrap of sub/add
    wr_d(0, 3); wr_d(1, 5); wr_d(2, 0); wr_d(10, 255); wr_d(11, 1); wr_d(12, 8'h55);
    wr_i(0, ins(2'b01, 0, 1, 2)); expect_d("t4_sub_wrap", 2, 254);
    wr_i(1, ins(2'b00, 10, 11, 12)); expect_d("t4_add_wrap", 12, 0);
    wr_i(2, ins(2'b11, 0, 0, 0));
    pulse_start(); wait_idle(c);
    drain();

    // reset during second mul cycle
    wr_d(0, 20); wr_d(1, 13); wr_d(3, 0); wr_d(9, 8'hAA);
    wr_i(0, ins(2'b00, 0, 1, 3));
    wr_i(1, ins(2'b10, 0, 1, 9));
    wr_i(2, ins(2'b11, 0, 0, 0));
    pulse_start();
    repeat (5) @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 1);
    chk("t5_retired_pre", 32'(retired), 1);
    rst = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_halted", 32'(halted), 0);
    chk("t5_rst_retired", 32'(retired), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_stay_idle", 32'(busy), 0);
    rd_d(9, v); chk("t5_d9_kept", 32'(v), 32'hAA);
    rd_d(3, v); chk("t5_d3_done", 32'(v), 33);
    wr_d(3, 0);
    expect_d("t5_rerun_d3", 3, 33); expect_d("t5_rerun_d9", 9, 4);
    pulse_start(); wait_idle(c);
    chk("t5_rerun_retired", 32'(retired), 2);
    chk("t5_rerun_halted", 32'(halted), 1);
    drain();

    // preload and start ignored while busy
    wr_d(0, 5); wr_d(1, 7); wr_d(20, 8'h11);
    wr_i(0, ins(2'b00, 0, 1, 2)); expect_d("t6_d2", 2, 12);
    wr_i(1, ins(2'b00, 2, 1, 3)); expect_d("t6_d3", 3, 19);
    wr_i(2, ins(2'b00, 3, 1, 4)); expect_d("t6_d4", 4, 26);
    wr_i(3, ins(2'b11, 0, 0, 0)); expect_d("t6_dmem_we_ignored", 20, 8'h11);
    pulse_start();
    imem_we = 1'b1; imem_addr = 5'd2; imem_wdata = ins(2'b11, 0, 0, 0);
    dmem_we = 1'b1; dmem_addr = 6'd20; dmem_wdata = 8'h77;
    start = 1'b1;
    @(negedge clk);
    imem_we = 1'b0; dmem_we = 1'b0; start = 1'b0;
    wait_idle(c);
    chk("t6_cycles", 32'(c + 1), 7);
    chk("t6_retired", 32'(retired), 3);
    drain();

    // no halt: pc wraps and retire keeps counting
    for (int i = 0; i < 32; i++) wr_i(i, ins(2'b00, 0, 1, 2));
    pulse_start();
    repeat (80) @(negedge clk);
    chk("t7_busy", 32'(busy), 1);
    chk("t7_halted", 32'(halted), 0);
    chk("t7_retired", 32'(retired), 77);
    rd_d(2, v); chk("t7_d2", 32'(v), 12);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("t7_stopped", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mini_core_p.md
MINI_CORE_P -- requirements
Module: mini_core_p

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data word width.
REQ-002 The block SHALL have parameter AW, default 6, meaning data-memory address width; the data memory holds 2^AW words.
REQ-003 The block SHALL have parameter IAW, default 5, meaning instruction-memory address width; the instruction memory holds 2^IAW words.
REQ-004 The block SHALL have parameter MUL_CYC, default 4 (minimum 1), meaning multiply occupancy in EX, in cycles.
REQ-005 The block SHALL have parameter CW, default 16, meaning retire-counter width.
REQ-006 The block SHALL use instruction width IW = 2+3*AW, encoded {op[1:0], src1[AW-1:0], src2[AW-1:0], dst[AW-1:0]}, with op 00 add, 01 sub, 10 mul, 11 halt.
REQ-007 The block SHALL have port clk, input, 1 bit: clock.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins execution at pc 0.
REQ-010 The block SHALL have ports imem_we (input, 1 bit), imem_addr (input, IAW bits) and imem_wdata (input, IW bits): instruction preload.
REQ-011 The block SHALL have ports dmem_we (input, 1 bit), dmem_addr (input, AW bits), dmem_wdata (input, DW bits) and dmem_rdata (output, DW bits): data preload and asynchronous readback of dmem[dmem_addr].
REQ-012 The block SHALL have ports busy (output, 1 bit), halted (output, 1 bit) and retired (output, CW bits): running flag, sticky halt flag and completed non-halt instruction count.

Function
REQ-013 The block SHALL use a three-stage pipeline: IF (registered imem[pc]), LD (registered dual operand read), EX (compute plus dmem write at the end of EX).
REQ-014 The block SHALL ignore preload writes while busy=1.
REQ-015 The block SHALL ignore start while busy=1.
REQ-016 On start while idle, the block SHALL set busy=1, clear halted and retired, set pc=0 and flush all stage valid bits.
REQ-017 The block SHALL complete add/sub in one EX cycle, writing (src1+src2) or (src1-src2) mod 2^DW to dst at the edge that ends EX.
REQ-018 For add/sub, the block SHALL commit the dst write at the 3rd rising edge after the edge that loaded the instruction into IF.
REQ-019 The block SHALL hold a mul in EX for MUL_CYC cycles and write the low DW bits of the product on the last of those cycles.
REQ-020 While a mul is incomplete, the block SHALL assert an internal freeze that holds pc, IF and LD unchanged, so that no instruction is dropped or duplicated.
REQ-021 When src1 or src2 in LD equals the dst being written by EX in the same cycle, the block SHALL forward the EX result, so back-to-back RAW hazards need no stall.
REQ-022 When src1 and src2 are both equal to that dst, the block SHALL forward to both operands.
REQ-023 When halt reaches EX, the block SHALL set halted=1 and busy=0, squash the younger IF and LD instructions without writes, and not count the halt in retired.
REQ-024 When pc reaches 2^IAW-1 without a halt, the block SHALL wrap pc to 0 and continue.
REQ-025 The retired counter SHALL wrap modulo 2^CW.
REQ-026 The block SHALL keep halted=1 until the next start or reset.
REQ-027 While busy=0, the block SHALL allow the pipeline to perform no dmem writes.

Reset
REQ-028 On rst low, the block SHALL immediately clear busy, halted, retired, pc, all valid bits and the mul cycle counter.
REQ-029 An in-flight instruction SHALL NOT write dmem when interrupted by reset.
REQ-030 The imem and dmem array contents SHALL be unaffected by reset.
REQ-031 After rst rises, the block SHALL stay idle until start.

Verification
REQ-032 The bench SHALL cover: dmem[0]=5, dmem[1]=7, imem={add 0,1->2; halt}, start -> dmem[2]=12 at edge 3 after first fetch, halted=1, busy=0, retired=1.
REQ-033 The bench SHALL cover: imem={add 0,1->2; sub 2,0->3; add 3,3->4; halt}, same data -> dmem[3]=7 and dmem[4]=14 with no stall cycles (forwarding).
REQ-034 The bench SHALL cover: dmem[0]=20, dmem[1]=13, imem={mul 0,1->2; add 2,0->5; halt}, MUL_CYC=4 -> dmem[2]=4 (260 mod 256), dmem[5]=24, and total run time 3 cycles longer than the all-add equivalent.
REQ-035 The bench SHALL cover: dmem[0]=3, dmem[1]=5, sub 0,1->2 -> dmem[2]=254; add 255+1 -> 0.
REQ-036 The bench SHALL cover: rst low during the 2nd mul cycle with dst=9 preloaded to 0xAA -> dmem[9]=0xAA, busy=0, halted=0, retired=0; a later start reruns correctly.
REQ-037 The bench SHALL cover: imem_we and start while busy=1 -> imem unchanged and no restart; program with no halt -> pc wraps and retired keeps incrementing.
